// File: rtl/usb_cmd_proc.sv
// Host command processor between the USB-in and USB-out FIFOs.
// Decodes ECHO / VERSION / REG_WR / REG_RD packets and owns a small control register file.
module usb_cmd_proc #(
  parameter int unsigned MAX_LEN = 256,
  parameter int unsigned REG_NUM = 8,
  parameter logic [31:0] FW_VER  = 32'h0001_0000,
  parameter logic [31:0] FW_DATE = 32'h2024_0101
) (
  input  logic        iCLK,
  input  logic        iRESET,
  input  logic        iIN_EMPTY,
  output logic        oIN_RD,
  input  logic [31:0] iIN_DATA,
  input  logic        iOUT_FULL,
  output logic        oOUT_WR,
  output logic [31:0] oOUT_DATA,
  output logic [31:0] oCTRL,
  output logic        oBUSY,
  output logic        oERR
);

  localparam logic [7:0] OP_ECHO  = 8'h01;
  localparam logic [7:0] OP_VER   = 8'h02;
  localparam logic [7:0] OP_WRREG = 8'h03;
  localparam logic [7:0] OP_RDREG = 8'h04;
  localparam logic [7:0] OP_ERR   = 8'hFF;
  localparam int AW = (REG_NUM > 1) ? $clog2(REG_NUM) : 1;

  typedef enum logic [2:0] {
    S_IDLE, S_HDR, S_DEC, S_RSP_HDR, S_PAY_RD, S_PAY_CAP, S_WR, S_DRAIN
  } state_t;

  state_t      state_q;
  logic        capDone_q;
  logic [7:0]  op_q;
  logic [7:0]  tag_q;
  logic [15:0] len_q;
  logic [15:0] cnt_q;
  logic        outPend_q;
  logic [31:0] outData_q;
  logic        err_q;
  logic        bad_q;
  logic        drain_q;
  logic        phase_q;
  logic [7:0]  addr_q;
  logic [1:0]  seq_q;
  logic [31:0] regs_q [REG_NUM];

  logic        outFire;
  logic        rdFire;
  logic        hdrLegal;
  logic [31:0] regRdData;

  // A pending output word blocks new reads, so FIFO back-pressure propagates upstream.
  assign outFire = outPend_q & ~iOUT_FULL;
  assign rdFire  = ~iIN_EMPTY & ~outPend_q &
                   ((state_q == S_HDR) |
                    (((state_q == S_PAY_RD) | (state_q == S_DRAIN)) & (cnt_q != 16'd0)));

  assign oIN_RD    = rdFire;
  assign oOUT_WR   = outFire;
  assign oOUT_DATA = outData_q;
  assign oCTRL     = regs_q[0];
  assign oBUSY     = (state_q != S_IDLE);
  assign oERR      = err_q;

  always_comb begin
    hdrLegal = 1'b0;
    case (op_q)
      OP_ECHO, OP_RDREG: hdrLegal = (len_q != 16'd0) && ({16'd0, len_q} <= MAX_LEN);
      OP_VER:            hdrLegal = (len_q == 16'd0);
      OP_WRREG:          hdrLegal = (len_q != 16'd0) && !len_q[0] && ({16'd0, len_q} <= MAX_LEN);
      default:           hdrLegal = 1'b0;
    endcase
  end

  always_comb begin
    regRdData = '0;
    if ({24'd0, iIN_DATA[7:0]} < REG_NUM) regRdData = regs_q[iIN_DATA[AW-1:0]];
  end

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state_q   <= S_IDLE;
      capDone_q <= 1'b0;
      op_q      <= '0;
      tag_q     <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      outPend_q <= 1'b0;
      outData_q <= '0;
      err_q     <= 1'b0;
      bad_q     <= 1'b0;
      drain_q   <= 1'b0;
      phase_q   <= 1'b0;
      addr_q    <= '0;
      seq_q     <= '0;
      for (int i = 0; i < int'(REG_NUM); i++) regs_q[i] <= '0;
    end else begin
      err_q <= 1'b0;
      if (outFire) outPend_q <= 1'b0;
      case (state_q)
        S_IDLE: if (!iIN_EMPTY) state_q <= S_HDR;
        S_HDR: if (rdFire) begin
          capDone_q <= 1'b0;
          state_q   <= S_DEC;
        end
        // First cycle captures the header, second cycle routes on the latched fields.
        S_DEC: if (!capDone_q) begin
          op_q      <= iIN_DATA[31:24];
          tag_q     <= iIN_DATA[23:16];
          len_q     <= iIN_DATA[15:0];
          cnt_q     <= iIN_DATA[15:0];
          capDone_q <= 1'b1;
        end else begin
          capDone_q <= 1'b0;
          bad_q     <= 1'b0;
          phase_q   <= 1'b0;
          drain_q   <= !hdrLegal;
          if (!hdrLegal)             state_q <= S_DRAIN;
          else if (op_q == OP_WRREG) state_q <= S_PAY_RD;
          else                       state_q <= S_RSP_HDR;
        end
        S_RSP_HDR: if (!outPend_q) begin
          outPend_q <= 1'b1;
          if (op_q == OP_VER) begin
            outData_q <= {OP_VER, tag_q, 16'd2};
            seq_q     <= 2'd0;
            state_q   <= S_WR;
          end else begin
            outData_q <= {op_q, tag_q, len_q};
            state_q   <= S_PAY_RD;
          end
        end
        S_PAY_RD: if (cnt_q == 16'd0) begin
          if (op_q != OP_WRREG) begin
            seq_q   <= 2'd2;
            state_q <= S_WR;
          end else if (!outPend_q) begin
            outPend_q <= 1'b1;
            outData_q <= {bad_q ? OP_ERR : OP_WRREG, tag_q, 16'd0};
            err_q     <= bad_q;
            seq_q     <= 2'd2;
            state_q   <= S_WR;
          end
        end else if (rdFire) begin
          state_q <= S_PAY_CAP;
        end
        // Reads only issue with no output pending, so loading here never overwrites a word.
        S_PAY_CAP: begin
          cnt_q <= cnt_q - 16'd1;
          if (drain_q) begin
            state_q <= S_DRAIN;
          end else begin
            state_q <= S_PAY_RD;
            case (op_q)
              OP_ECHO: begin
                outPend_q <= 1'b1;
                outData_q <= iIN_DATA;
              end
              OP_RDREG: begin
                outPend_q <= 1'b1;
                outData_q <= regRdData;
              end
              OP_WRREG: begin
                phase_q <= ~phase_q;
                if (!phase_q)                         addr_q <= iIN_DATA[7:0];
                else if ({24'd0, addr_q} < REG_NUM)   regs_q[addr_q[AW-1:0]] <= iIN_DATA;
                else                                  bad_q <= 1'b1;
              end
              default: ;
            endcase
          end
        end
        S_DRAIN: if (cnt_q == 16'd0) begin
          if (!outPend_q) begin
            outPend_q <= 1'b1;
            outData_q <= {OP_ERR, tag_q, 16'd0};
            err_q     <= 1'b1;
            seq_q     <= 2'd2;
            state_q   <= S_WR;
          end
        end else if (rdFire) begin
          state_q <= S_PAY_CAP;
        end
        S_WR: if (!outPend_q) begin
          case (seq_q)
            2'd0: begin
              outPend_q <= 1'b1;
              outData_q <= FW_VER;
              seq_q     <= 2'd1;
            end
            2'd1: begin
              outPend_q <= 1'b1;
              outData_q <= FW_DATE;
              seq_q     <= 2'd2;
            end
            default: state_q <= S_IDLE;
          endcase
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
